scoreboard_buffer: RTL and testbench

- Parametrised in-order scoreboard: circular buffer of `NR_ENTRIES` issued instructions (`scoreboard_entry`), out-of-order completion through `NR_WB_PORTS` writeback ports, in-order commit.
- Sits between issue and commit stages.
- Adds what the fixed 4-entry/2-port design lacked:
  - generic depth and port count;
  - per-register clobber tracking;
  - operand forwarding;
  - single-cycle flush.

---
 rtl/scoreboard_buffer.sv | 177 +++++++++++++++++
 tb/tb_scoreboard_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_buffer.sv
// In-order scoreboard: circular buffer of issued instructions with out-of-order
// writeback, in-order commit, per-register clobber tracking and operand forwarding.
package scoreboard_pkg;
  localparam int TID_FIELD_W = 8;

  typedef enum logic [2:0] {
    FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]            pc;
    logic [TID_FIELD_W-1:0] trans_id;
    fu_t                    fu;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [63:0]            result;
    logic                   valid;
    exception_t             ex;
  } scoreboard_entry_t;
endpackage

module scoreboard_buffer
  import scoreboard_pkg::*;
#(
  parameter int NR_ENTRIES  = 4,
  parameter int NR_WB_PORTS = 2,
  localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  output logic                                        full_o,
  input  scoreboard_entry_t                           issue_instr_i,
  input  logic                                        issue_valid_i,
  output logic                                        issue_ack_o,
  output logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                wb_data_i,
  input  exception_t [NR_WB_PORTS-1:0]                wb_ex_i,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  output scoreboard_entry_t                           commit_instr_o,
  output logic                                        commit_valid_o,
  input  logic                                        commit_ack_i,
  input  logic [4:0]                                  rs1_i,
  input  logic [4:0]                                  rs2_i,
  output logic [63:0]                                 rs1_o,
  output logic [63:0]                                 rs2_o,
  output logic                                        rs1_valid_o,
  output logic                                        rs2_valid_o,
  output fu_t [31:0]                                  rd_clobber_o
);
  localparam int CNT_W = TRANS_ID_BITS + 1;

  scoreboard_entry_t        mem_q [NR_ENTRIES];
  scoreboard_entry_t        mem_d [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [NR_ENTRIES-1:0]    occupied;
  logic                     commit_fire;
  logic [TRANS_ID_BITS-1:0] idx;

  assign full_o           = (count_q == CNT_W'(NR_ENTRIES));
  assign issue_ack_o      = issue_valid_i && !full_o && !flush_i;
  assign issue_trans_id_o = tail_q;
  assign commit_instr_o   = mem_q[head_q];
  assign commit_valid_o   = (count_q != '0) && mem_q[head_q].valid;
  assign commit_fire      = commit_valid_o && commit_ack_i && !flush_i;

  // An entry is occupied when its distance from head (mod depth) is below count.
  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      occupied[i] = ({1'b0, TRANS_ID_BITS'(i) - head_q} < count_q);
    end
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Ascending port order lets the highest port index win on a shared id.
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p] && occupied[wb_trans_id_i[p]] &&
          !(issue_ack_o && (wb_trans_id_i[p] == tail_q))) begin
        mem_d[wb_trans_id_i[p]].result = wb_data_i[p];
        mem_d[wb_trans_id_i[p]].valid  = 1'b1;
        if (wb_ex_i[p].valid) begin
          mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
        end
      end
    end

    if (commit_fire) begin
      mem_d[head_q] = '0;
      head_d        = head_q + TRANS_ID_BITS'(1);
    end

    if (issue_ack_o) begin
      mem_d[tail_q]          = issue_instr_i;
      mem_d[tail_q].trans_id = TID_FIELD_W'(tail_q);
      tail_d                 = tail_q + TRANS_ID_BITS'(1);
    end

    case ({issue_ack_o, commit_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        mem_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so later (younger) matches overwrite earlier ones.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      rd_clobber_o[r] = FU_NONE;
    end
    rs1_o       = '0;
    rs2_o       = '0;
    rs1_valid_o = 1'b0;
    rs2_valid_o = 1'b0;
    idx         = '0;
    for (int k = 0; k < NR_ENTRIES; k++) begin
      idx = head_q + TRANS_ID_BITS'(k);
      if (CNT_W'(k) < count_q) begin
        rd_clobber_o[mem_q[idx].rd] = mem_q[idx].fu;
        if (mem_q[idx].rd == rs1_i) begin
          rs1_valid_o = mem_q[idx].valid;
          rs1_o       = mem_q[idx].valid ? mem_q[idx].result : '0;
        end
        if (mem_q[idx].rd == rs2_i) begin
          rs2_valid_o = mem_q[idx].valid;
          rs2_o       = mem_q[idx].valid ? mem_q[idx].result : '0;
        end
      end
    end
    rd_clobber_o[0] = FU_NONE;
    if (rs1_i == 5'd0) begin
      rs1_valid_o = 1'b0;
      rs1_o       = '0;
    end
    if (rs2_i == 5'd0) begin
      rs2_valid_o = 1'b0;
      rs2_o       = '0;
    end
  end
endmodule

// File: tb/tb_scoreboard_buffer.sv
// Self-checking bench for scoreboard_buffer: directed scenarios plus a randomized
// run checked against a queue-based reference model of the in-flight instructions.
module tb_scoreboard_buffer;
  import scoreboard_pkg::*;

  localparam int NR  = 4;
  localparam int NWB = 2;
  localparam int TB  = 2;

  typedef fu_t [31:0] clob_t;
  typedef struct {
    int                id;
    scoreboard_entry_t e;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush;
  logic full;
  scoreboard_entry_t issue_instr;
  logic issue_valid, issue_ack;
  logic [TB-1:0] issue_tid;
  logic [NWB-1:0][TB-1:0] wb_tid;
  logic [NWB-1:0][63:0] wb_data;
  exception_t [NWB-1:0] wb_ex;
  logic [NWB-1:0] wb_valid;
  scoreboard_entry_t commit_instr;
  logic commit_valid, commit_ack;
  logic [4:0] rs1, rs2;
  logic [63:0] rs1_o, rs2_o;
  logic rs1_v, rs2_v;
  clob_t clob;

  int n_cmp = 0;
  int n_fail = 0;

  slot_t mq[$];
  int mhead = 0;
  clob_t none_clob;

  always #5 clk = ~clk;

  scoreboard_buffer #(.NR_ENTRIES(NR), .NR_WB_PORTS(NWB)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .full_o(full),
    .issue_instr_i(issue_instr), .issue_valid_i(issue_valid),
    .issue_ack_o(issue_ack), .issue_trans_id_o(issue_tid),
    .wb_trans_id_i(wb_tid), .wb_data_i(wb_data), .wb_ex_i(wb_ex), .wb_valid_i(wb_valid),
    .commit_instr_o(commit_instr), .commit_valid_o(commit_valid), .commit_ack_i(commit_ack),
    .rs1_i(rs1), .rs2_i(rs2), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rs1_valid_o(rs1_v), .rs2_valid_o(rs2_v), .rd_clobber_o(clob)
  );

  function automatic scoreboard_entry_t mk(fu_t fu, logic [4:0] rd, logic v, logic [63:0] res);
    scoreboard_entry_t e;
    e        = '0;
    e.fu     = fu;
    e.rd     = rd;
    e.valid  = v;
    e.result = res;
    e.pc     = 64'h1000 + res;
    return e;
  endfunction

  // Reference model: queue ordered oldest to youngest, updated at each clock edge.
  task automatic model_update();
    bit m_full, m_ack, m_cv;
    int tail;
    scoreboard_entry_t e;
    m_full = (mq.size() == NR);
    m_ack  = issue_valid && !m_full && !flush;
    m_cv   = (mq.size() > 0) && mq[0].e.valid;
    tail   = (mhead + mq.size()) % NR;
    if (flush) begin
      mq.delete();
      mhead = 0;
      return;
    end
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p] && !(m_ack && int'(wb_tid[p]) == tail)) begin
        foreach (mq[k]) begin
          if (mq[k].id == int'(wb_tid[p])) begin
            mq[k].e.result = wb_data[p];
            mq[k].e.valid  = 1'b1;
            if (wb_ex[p].valid) mq[k].e.ex = wb_ex[p];
          end
        end
      end
    end
    if (m_cv && commit_ack) begin
      void'(mq.pop_front());
      mhead = (mhead + 1) % NR;
    end
    if (m_ack) begin
      e = issue_instr;
      e.trans_id = 8'(tail);
      mq.push_back('{id: tail, e: e});
    end
  endtask

  function automatic clob_t model_clob();
    clob_t c;
    for (int r = 0; r < 32; r++) c[r] = FU_NONE;
    foreach (mq[k]) c[mq[k].e.rd] = mq[k].e.fu;
    c[0] = FU_NONE;
    return c;
  endfunction

  function automatic void model_fwd(input logic [4:0] rs, output bit found, output bit v,
                                    output logic [63:0] val);
    found = 0; v = 0; val = '0;
    if (rs == 5'd0) return;
    for (int k = mq.size() - 1; k >= 0; k--) begin
      if (mq[k].e.rd == rs) begin
        found = 1;
        v     = mq[k].e.valid;
        val   = mq[k].e.valid ? mq[k].e.result : 64'd0;
        return;
      end
    end
  endfunction

  task automatic idle();
    flush = 0; issue_valid = 0; issue_instr = '0; commit_ack = 0;
    wb_valid = '0; wb_tid = '0; wb_data = '0; wb_ex = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    mq.delete();
    mhead = 0;
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #2;
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cv got=%b exp=0", commit_valid); end
    n_cmp++; if (issue_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", issue_ack); end
    n_cmp++; if (clob !== none_clob) begin n_fail++; $display("FAIL reset_clob got=%h exp=%h", clob, none_clob); end
    do_reset();
  endtask

  task automatic test_fill_wrap();
    logic [63:0] exp_res [4] = '{64'd1, 64'd2, 64'd3, 64'd10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_instr = mk(FU_ALU, 5'(i + 1), 1'b1, 64'(i));
      #1;
      n_cmp++; if (issue_ack !== 1'b1 || issue_tid !== TB'(i)) begin
        n_fail++; $display("FAIL fill_issue%0d ack=%b id=%0d exp ack=1 id=%0d", i, issue_ack, issue_tid, i); end
      cycle();
    end
    issue_valid = 1; issue_instr = mk(FU_ALU, 5'd9, 1'b1, 64'd10); commit_ack = 1;
    #1;
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", full); end
    n_cmp++; if (issue_ack !== 1'b0) begin n_fail++; $display("FAIL fill_refuse got=%b exp=0", issue_ack); end
    n_cmp++; if (commit_valid !== 1'b1 || commit_instr.result !== 64'd0) begin
      n_fail++; $display("FAIL fill_commit0 cv=%b res=%h exp cv=1 res=0", commit_valid, commit_instr.result); end
    cycle();
    commit_ack = 0;
    #1;
    n_cmp++; if (issue_ack !== 1'b1 || issue_tid !== 2'd0) begin
      n_fail++; $display("FAIL wrap_id ack=%b id=%0d exp ack=1 id=0", issue_ack, issue_tid); end
    cycle();
    issue_valid = 0;
    #1;
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got=%b exp=1", full); end
    commit_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (commit_valid !== 1'b1 || commit_instr.result !== exp_res[i]) begin
        n_fail++; $display("FAIL drain%0d cv=%b res=%h exp cv=1 res=%h", i, commit_valid, commit_instr.result, exp_res[i]); end
      cycle();
    end
    commit_ack = 0;
    #1;
    n_cmp++; if (commit_valid !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty cv=%b full=%b exp 0 0", commit_valid, full); end
  endtask

  task automatic test_ooo_commit();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      issue_valid = 1; issue_instr = mk(FU_ALU, 5'(i + 1), 1'b0, 64'd0);
      cycle();
    end
    issue_valid = 0;
    wb_valid = 2'b01; wb_tid[0] = 2'd1; wb_data[0] = 64'hBEEF;
    cycle();
    wb_valid = '0;
    #1;
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_head_pending got=%b exp=0", commit_valid); end
    wb_valid = 2'b01; wb_tid[0] = 2'd0; wb_data[0] = 64'h1;
    #1;
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_no_bypass got=%b exp=0", commit_valid); end
    cycle();
    wb_valid = '0; commit_ack = 1;
    #1;
    n_cmp++; if (commit_valid !== 1'b1 || commit_instr.result !== 64'h1) begin
      n_fail++; $display("FAIL ooo_first cv=%b res=%h exp cv=1 res=1", commit_valid, commit_instr.result); end
    cycle();
    n_cmp++; if (commit_valid !== 1'b1 || commit_instr.result !== 64'hBEEF) begin
      n_fail++; $display("FAIL ooo_second cv=%b res=%h exp cv=1 res=beef", commit_valid, commit_instr.result); end
    cycle();
    commit_ack = 0;
    #1;
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_empty got=%b exp=0", commit_valid); end
  endtask

  task automatic test_port_conflict();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_instr = mk(FU_LOAD, 5'(i + 4), 1'b0, 64'd0);
      cycle();
    end
    issue_valid = 0;
    wb_valid = 2'b11; wb_tid[0] = 2'd2; wb_tid[1] = 2'd2;
    wb_data[0] = 64'hAA; wb_data[1] = 64'hBB;
    wb_ex[0].cause = 64'h5; wb_ex[0].valid = 1'b1;
    cycle();
    wb_ex = '0; wb_tid[0] = 2'd0; wb_tid[1] = 2'd1; wb_data[0] = 64'h1; wb_data[1] = 64'h2;
    cycle();
    wb_valid = '0; commit_ack = 1;
    cycle();
    cycle();
    n_cmp++; if (commit_valid !== 1'b1 || commit_instr.result !== 64'hBB) begin
      n_fail++; $display("FAIL conflict_result cv=%b res=%h exp cv=1 res=bb", commit_valid, commit_instr.result); end
    n_cmp++; if (commit_instr.ex.valid !== 1'b1 || commit_instr.ex.cause !== 64'h5) begin
      n_fail++; $display("FAIL conflict_ex valid=%b cause=%h exp valid=1 cause=5", commit_instr.ex.valid, commit_instr.ex.cause); end
    cycle();
    commit_ack = 0;
  endtask

  task automatic test_clobber_forward();
    do_reset();
    issue_valid = 1; issue_instr = mk(FU_ALU, 5'd5, 1'b0, 64'd0);  cycle();
    issue_instr = mk(FU_MULT, 5'd5, 1'b0, 64'd0); cycle();
    issue_instr = mk(FU_CSR, 5'd0, 1'b1, 64'd7);  cycle();
    issue_valid = 0; rs1 = 5'd5;
    #1;
    n_cmp++; if (clob[5] !== FU_MULT) begin n_fail++; $display("FAIL clob5 got=%0d exp=%0d", clob[5], FU_MULT); end
    n_cmp++; if (clob[0] !== FU_NONE) begin n_fail++; $display("FAIL clob0 got=%0d exp=0", clob[0]); end
    n_cmp++; if (rs1_v !== 1'b0 || rs1_o !== 64'd0) begin
      n_fail++; $display("FAIL fwd_pending v=%b val=%h exp v=0 val=0", rs1_v, rs1_o); end
    wb_valid = 2'b10; wb_tid[1] = 2'd1; wb_data[1] = 64'h42;
    #1;
    n_cmp++; if (rs1_v !== 1'b0) begin n_fail++; $display("FAIL fwd_no_bypass got=%b exp=0", rs1_v); end
    cycle();
    wb_valid = '0;
    #1;
    n_cmp++; if (rs1_v !== 1'b1 || rs1_o !== 64'h42) begin
      n_fail++; $display("FAIL fwd_ready v=%b val=%h exp v=1 val=42", rs1_v, rs1_o); end
    rs1 = 5'd0;
    #1;
    n_cmp++; if (rs1_v !== 1'b0) begin n_fail++; $display("FAIL fwd_x0 got=%b exp=0", rs1_v); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_instr = mk(FU_LOAD, 5'(i + 3), 1'b1, 64'(i));
      cycle();
    end
    flush = 1; issue_valid = 1; commit_ack = 1;
    #1;
    n_cmp++; if (issue_ack !== 1'b0) begin n_fail++; $display("FAIL flush_ack got=%b exp=0", issue_ack); end
    cycle();
    flush = 0; issue_valid = 0; commit_ack = 0;
    #1;
    n_cmp++; if (commit_valid !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty cv=%b full=%b exp 0 0", commit_valid, full); end
    n_cmp++; if (clob !== none_clob) begin n_fail++; $display("FAIL flush_clob got=%h exp=%h", clob, none_clob); end
    issue_valid = 1; issue_instr = mk(FU_ALU, 5'd1, 1'b0, 64'd0);
    #1;
    n_cmp++; if (issue_ack !== 1'b1 || issue_tid !== 2'd0) begin
      n_fail++; $display("FAIL flush_reissue ack=%b id=%0d exp ack=1 id=0", issue_ack, issue_tid); end
    cycle();
    issue_valid = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      issue_valid = 1; issue_instr = mk(FU_LOAD, 5'(i + 3), 1'b1, 64'(i));
      cycle();
    end
    issue_valid = 0;
    #1;
    n_cmp++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre cv=%b exp=1", commit_valid); end
    rst = 1;
    #1;
    n_cmp++; if (commit_valid !== 1'b0 || full !== 1'b0 || clob !== none_clob) begin
      n_fail++; $display("FAIL areset_now cv=%b full=%b clob=%h exp 0 0 none", commit_valid, full, clob); end
    rst = 0;
    mq.delete();
    mhead = 0;
    issue_valid = 1; issue_instr = mk(FU_ALU, 5'd2, 1'b0, 64'd0);
    #1;
    n_cmp++; if (issue_ack !== 1'b1 || issue_tid !== 2'd0) begin
      n_fail++; $display("FAIL areset_id ack=%b id=%0d exp ack=1 id=0", issue_ack, issue_tid); end
    cycle();
    issue_valid = 0;
  endtask

  task automatic test_random();
    bit e_full, e_ack, e_cv, f1, v1, f2, v2;
    logic [63:0] val1, val2;
    int tail;
    clob_t e_clob;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      flush       = ($urandom_range(0, 31) == 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_instr = mk(fu_t'(3'($urandom_range(1, 6))), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 3) == 0), {$urandom, $urandom});
      issue_instr.ex.valid = 1'($urandom_range(0, 7) == 0);
      issue_instr.ex.cause = 64'($urandom_range(0, 15));
      commit_ack = 1'($urandom_range(0, 1));
      for (int p = 0; p < NWB; p++) begin
        wb_valid[p]    = 1'($urandom_range(0, 2) == 0);
        wb_tid[p]      = TB'($urandom_range(0, NR - 1));
        wb_data[p]     = {$urandom, $urandom};
        wb_ex[p].valid = 1'($urandom_range(0, 3) == 0);
        wb_ex[p].cause = 64'($urandom_range(0, 15));
      end
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      #1;
      e_full = (mq.size() == NR);
      e_ack  = issue_valid && !e_full && !flush;
      e_cv   = (mq.size() > 0) && mq[0].e.valid;
      tail   = (mhead + mq.size()) % NR;
      e_clob = model_clob();
      model_fwd(rs1, f1, v1, val1);
      model_fwd(rs2, f2, v2, val2);
      n_cmp++; if (full !== e_full) begin n_fail++; $display("FAIL rnd%0d full got=%b exp=%b", c, full, e_full); end
      n_cmp++; if (issue_ack !== e_ack) begin n_fail++; $display("FAIL rnd%0d ack got=%b exp=%b", c, issue_ack, e_ack); end
      if (e_ack) begin
        n_cmp++; if (int'(issue_tid) != tail) begin n_fail++; $display("FAIL rnd%0d tid got=%0d exp=%0d", c, issue_tid, tail); end
      end
      n_cmp++; if (commit_valid !== e_cv) begin n_fail++; $display("FAIL rnd%0d cv got=%b exp=%b", c, commit_valid, e_cv); end
      if (e_cv) begin
        n_cmp++; if (commit_instr !== mq[0].e) begin
          n_fail++; $display("FAIL rnd%0d commit_instr got=%h exp=%h", c, commit_instr, mq[0].e); end
      end
      n_cmp++; if (clob !== e_clob) begin n_fail++; $display("FAIL rnd%0d clob got=%h exp=%h", c, clob, e_clob); end
      n_cmp++; if (rs1_v !== v1 || (f1 && rs1_o !== val1)) begin
        n_fail++; $display("FAIL rnd%0d rs1 v=%b val=%h exp v=%b val=%h", c, rs1_v, rs1_o, v1, val1); end
      n_cmp++; if (rs2_v !== v2 || (f2 && rs2_o !== val2)) begin
        n_fail++; $display("FAIL rnd%0d rs2 v=%b val=%h exp v=%b val=%h", c, rs2_v, rs2_o, v2, val2); end
      cycle();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 32; r++) none_clob[r] = FU_NONE;
    test_reset();
    test_fill_wrap();
    test_ooo_commit();
    test_port_conflict();
    test_clobber_forward();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
